// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter for the CS4272 with clock generation and codec reset sequencing
// Ports: clk/rst system clock and sync reset; lft_in/rht_in/valid sample input with ready,
// samp_req frame-start pulse; err_clr clears sticky overflow/underrun;
// MCLK/SCLK/LRCLK/SDin/RSTn codec interface.
// Option: define I2S_MUTE_UNDERRUN_EN to send a silent frame on underrun instead of repeating.
module i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int RST_HOLD = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rht_in,
  input  logic              valid,
  output logic              ready,
  output logic              samp_req,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underrun,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin,
  output logic              RSTn
);
  localparam int HW = $clog2(RST_HOLD + 1);
  logic [10:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] lft_q, lft_d, rht_q, rht_d, pl_q, pl_d, pr_q, pr_d, rep_l, rep_r, word;
  logic              full_q, full_d, ovf_q, ovf_d, und_q, und_d, req_q, req_d;
  logic              mclk_q, mclk_d, sclk_q, sclk_d, lrclk_q, lrclk_d, sdin_q, sdin_d;
  logic              rstn_q, rstn_d, load, cap;
  logic [HW-1:0]     hold_q, hold_d;
  logic [31:0]       slots;
`ifdef I2S_MUTE_UNDERRUN_EN
  assign rep_l = '0;
  assign rep_r = '0;
`else
  assign rep_l = lft_q;
  assign rep_r = rht_q;
`endif
  always_comb begin
    cnt_d   = cnt_q + 11'd1;
    load    = &cnt_q;
    // pending captures outside the load cycle when empty, or in the load cycle when it is being drained
    cap     = valid & (full_q ? load : ~load);
    lft_d   = load ? (full_q ? pl_q : valid ? lft_in : rep_l) : lft_q;
    rht_d   = load ? (full_q ? pr_q : valid ? rht_in : rep_r) : rht_q;
    pl_d    = cap ? lft_in : pl_q;
    pr_d    = cap ? rht_in : pr_q;
    full_d  = full_q ? (~load | valid) : (valid & ~load);
    ovf_d   = (ovf_q & ~err_clr) | (valid & full_q & ~load);
    und_d   = (und_q & ~err_clr) | (load & ~full_q & ~valid);
    req_d   = load;
    mclk_d  = cnt_q[1];
    sclk_d  = cnt_q[4];
    lrclk_d = cnt_q[10];
    word    = cnt_q[10] ? rht_q : lft_q;
    // slot s maps to bit 31-s: slot 0 is the I2S delay bit, then MSB-first data, then zero fill
    slots   = {1'b0, word, {(31 - DATA_W){1'b0}}};
    sdin_d  = slots[~cnt_q[9:5]];
    hold_d  = rstn_q ? hold_q : hold_q + 1'b1;
    rstn_d  = rstn_q | (hold_q == HW'(RST_HOLD - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      lft_q   <= '0;
      rht_q   <= '0;
      pl_q    <= '0;
      pr_q    <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
      req_q   <= 1'b0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdin_q  <= 1'b0;
      rstn_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lft_q   <= lft_d;
      rht_q   <= rht_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
      req_q   <= req_d;
      mclk_q  <= mclk_d;
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
      sdin_q  <= sdin_d;
      rstn_q  <= rstn_d;
      hold_q  <= hold_d;
    end
  end
  assign ready    = ~full_q;
  assign samp_req = req_q;
  assign overflow = ovf_q;
  assign underrun = und_q;
  assign MCLK     = mclk_q;
  assign SCLK     = sclk_q;
  assign LRCLK    = lrclk_q;
  assign SDin     = sdin_q;
  assign RSTn     = rstn_q;
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S transmitter between the equalizer's sample output and the CS4272 codec.
- Accepts one stereo sample per frame through a one-entry buffer, serializes it MSB-first in standard I2S format, and generates MCLK/SCLK/LRCLK from the 50 MHz system clock (fs = 50 MHz / 2048 ≈ 24414 Hz).
- Sequences the codec reset pin (RSTn) after system reset.

Parameters:
- DATA_W, 16, sample width per channel (1..24); unused slot bits are sent as 0.
- RST_HOLD, 4096, number of clk cycles RSTn is held low after rst deasserts.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- lft_in  in  DATA_W  left sample, signed.
- rht_in  in  DATA_W  right sample, signed.
- valid  in  1  lft_in/rht_in present this cycle.
- ready  out  1  pending buffer empty (= ~full).
- samp_req  out  1  one-clk pulse: a frame just started; upstream should supply the next sample.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky: valid arrived while buffer full.
- underrun  out  1  sticky: frame started with no new sample.
- MCLK  out  1  clk/4 (12.5 MHz).
- SCLK  out  1  clk/32, 64 SCLK per frame.
- LRCLK  out  1  clk/2048; 0 = left half, 1 = right half.
- SDin  out  1  serial data to codec (codec input).
- RSTn  out  1  codec reset, active-low.

Behaviour:
- Timing counter
  - 11-bit free-running cnt, increments every clk, wraps 2047 -> 0.
  - All outputs are registered, so each output reflects cnt one clk later.
  - MCLK = cnt[1], SCLK = cnt[4], LRCLK = cnt[10].
  - Slot index s = cnt[9:5] (0..31) within each half-frame.
- Serial data
  - SDin changes only when SCLK falls (cnt[4:0] 31 -> 0). Codec samples on SCLK rise.
  - Slot s = 1..DATA_W carries channel bit (DATA_W - s), MSB first.
  - Slot 0 (the I2S one-bit delay) and slots DATA_W+1..31 carry 0.
  - Left word is sent while LRCLK = 0, right word while LRCLK = 1.
- Frame load
  - Occurs on the clk where cnt = 2047.
  - Active left/right registers are loaded from the pending buffer if full; full is then cleared.
  - If not full and valid is high in that same cycle: lft_in/rht_in load directly into the active registers. full stays 0 and no underrun is flagged.
  - If not full and valid is low: active registers keep their previous sample (repeat) and underrun is set.
  - samp_req pulses high for exactly one clk, on the cycle after the load (cnt = 0).
- Buffer
  - valid with full = 0 (other than the load cycle) captures lft_in/rht_in into pending and sets full.
  - valid with full = 1 drops the new sample, keeps the pending one, and sets overflow.
  - A valid in the same cycle as a load while full = 1: the load empties the buffer and the new sample is captured (full stays 1). No overflow.
- Flags
  - overflow and underrun are sticky until err_clr or rst.
  - If err_clr coincides with a new error event, the set wins.
- Codec reset
  - After rst deasserts, RSTn = 0 for RST_HOLD clks, then 1 until the next rst.
  - Clocks run during the hold.
- Reset values
  - cnt = 0; MCLK = SCLK = LRCLK = SDin = 0; RSTn = 0; samp_req = 0.
  - ready = 1; overflow = underrun = 0; active and pending registers = 0.
  - rst asserted mid-frame forces all of the above on the next clk edge and restarts the RSTn hold.
- Underrun at the first frame after reset is expected and flagged normally.

Optional Feature:
- Macro: I2S_MUTE_UNDERRUN_EN.
- Defined: on underrun, the active registers load 0 (muted frame) instead of repeating the previous sample. underrun is still set.
- Undefined: the previous sample is repeated.

Test Plan:
- Clocks and reset: release rst -> RSTn low for exactly 4096 clks, then high. MCLK period 4 clks, SCLK period 32, LRCLK period 2048, 50% duty on each, all low at reset.
- Serialization: valid with lft_in = 0xA5C3, rht_in = 0x1234 before cnt = 2047 -> next frame, sampled on SCLK rise:
  - left slots 1..16 = 1010_0101_1100_0011, right slots 1..16 = 0001_0010_0011_0100;
  - slots 0 and 17..31 = 0;
  - samp_req pulses once at cnt = 0.
- Overflow: two valid pulses in one frame (0x1111, then 0x2222) -> ready = 0 after the first, overflow = 1; 0x1111 is transmitted and 0x2222 never appears. err_clr -> overflow = 0.
- Underrun: frame with 0x7FFF, then no valid for one frame -> underrun = 1. Second frame repeats 0x7FFF; with I2S_MUTE_UNDERRUN_EN it sends 0x0000.
- Load-cycle bypass: buffer empty, valid with 0x8000 exactly at cnt = 2047 -> 0x8000 sent in the following frame, underrun stays 0, ready stays 1.
- Reset mid-operation: assert rst at cnt = 1000 mid-serialization -> next clk all outputs at reset values, and RSTn hold restarts for 4096 clks.
